// File: rtl/video_mem_responder.sv
// video_mem_responder
//   Memory side of the PPU: owns the 8 KiB VRAM and the OAM, answers both PPU
//   read ports and the CPU port with a fixed one-cycle latency, and runs the
//   OAM DMA engine that copies OAM_BYTES bytes from the external bus into OAM.
// Ports:
//   clk_in, rst_n_in            clock, asynchronous active-low reset
//   mode_in                     PPU mode (0 HBlank, 1 VBlank, 2 OAMScan, 3 Draw)
//   ppu_addr_* / ppu_data_*     PPU general read port (VRAM or OAM)
//   ppu_oam_addr_* / _data_*    PPU sprite-flag read port
//   cpu_*                       CPU read/write port, gated by PPU mode and DMA
//   dma_start_in, dma_src_hi_in DMA kick-off and source page
//   dma_addr/req_out, dma_data* DMA external bus read interface
//   dma_busy_out                DMA transfer in progress
module video_mem_responder #(
    parameter logic [15:0] VRAM_BASE = 16'h8000,
    parameter logic [15:0] OAM_BASE  = 16'hFE00,
    parameter int          OAM_BYTES = 160
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [1:0]  mode_in,
    input  logic [15:0] ppu_addr_in,
    input  logic        ppu_addr_valid_in,
    output logic [7:0]  ppu_data_out,
    output logic        ppu_data_valid_out,
    input  logic [15:0] ppu_oam_addr_in,
    input  logic        ppu_oam_addr_valid_in,
    output logic [7:0]  ppu_oam_data_out,
    output logic        ppu_oam_data_valid_out,
    input  logic [15:0] cpu_addr_in,
    input  logic        cpu_req_in,
    input  logic        cpu_we_in,
    input  logic [7:0]  cpu_wdata_in,
    output logic [7:0]  cpu_rdata_out,
    output logic        cpu_rdata_valid_out,
    input  logic        dma_start_in,
    input  logic [7:0]  dma_src_hi_in,
    output logic [15:0] dma_addr_out,
    output logic        dma_req_out,
    input  logic [7:0]  dma_data_in,
    input  logic        dma_data_valid_in,
    output logic        dma_busy_out
);

    localparam logic [15:0] VRAM_LAST = VRAM_BASE + 16'h1FFF;
    localparam logic [15:0] OAM_LAST  = OAM_BASE + 16'(OAM_BYTES - 1);
    localparam logic [7:0]  IDX_LAST  = 8'(OAM_BYTES - 1);

    typedef enum logic [1:0] {DMA_IDLE, DMA_REQ, DMA_WAIT} dma_state_e;

    logic [7:0] vram_mem [8192];
    logic [7:0] oam_mem  [OAM_BYTES];

    function automatic logic in_vram(input logic [15:0] a);
        return (a >= VRAM_BASE) && (a <= VRAM_LAST);
    endfunction

    function automatic logic in_oam(input logic [15:0] a);
        return (a >= OAM_BASE) && (a <= OAM_LAST);
    endfunction

    function automatic logic [12:0] vram_ix(input logic [15:0] a);
        return 13'(a - VRAM_BASE);
    endfunction

    function automatic logic [7:0] oam_ix(input logic [15:0] a);
        return 8'(a - OAM_BASE);
    endfunction

    dma_state_e  dma_state_q, dma_state_d;
    logic [7:0]  dma_idx_q, dma_idx_d;
    logic [7:0]  dma_src_q, dma_src_d;
    logic [7:0]  ppu_data_q, ppu_data_d;
    logic        ppu_valid_q, ppu_valid_d;
    logic [7:0]  spr_data_q, spr_data_d;
    logic        spr_valid_q, spr_valid_d;
    logic [7:0]  cpu_data_q, cpu_data_d;
    logic        cpu_valid_q, cpu_valid_d;

    logic        dma_busy;
    logic        cpu_vram_ok, cpu_oam_ok;
    logic        vram_we, oam_we, dma_wr;
    logic [7:0]  oam_wa, oam_wd;
    logic [7:0]  ppu_rd, spr_rd, cpu_rd;

    assign dma_busy = (dma_state_q != DMA_IDLE);

    // CPU gating uses the mode present at the request edge.
    assign cpu_vram_ok = in_vram(cpu_addr_in) && (mode_in != 2'd3);
    assign cpu_oam_ok  = in_oam(cpu_addr_in) && !mode_in[1] && !dma_busy;

    // A restart in the same cycle as a bus response discards that response.
    assign dma_wr  = (dma_state_q == DMA_WAIT) && dma_data_valid_in && !dma_start_in;
    assign vram_we = cpu_req_in && cpu_we_in && cpu_vram_ok;
    assign oam_we  = dma_wr || (cpu_req_in && cpu_we_in && cpu_oam_ok);
    assign oam_wa  = dma_wr ? dma_idx_q : oam_ix(cpu_addr_in);
    assign oam_wd  = dma_wr ? dma_data_in : cpu_wdata_in;

    // Reads sample the array before this edge's write lands (read-first).
    always_comb begin
        ppu_rd = 8'hFF;
        if (in_vram(ppu_addr_in))
            ppu_rd = vram_mem[vram_ix(ppu_addr_in)];
        else if (in_oam(ppu_addr_in) && !dma_busy)
            ppu_rd = oam_mem[oam_ix(ppu_addr_in)];

        spr_rd = 8'hFF;
        if (in_vram(ppu_oam_addr_in))
            spr_rd = vram_mem[vram_ix(ppu_oam_addr_in)];
        else if (in_oam(ppu_oam_addr_in) && !dma_busy)
            spr_rd = oam_mem[oam_ix(ppu_oam_addr_in)];

        cpu_rd = 8'hFF;
        if (cpu_vram_ok)
            cpu_rd = vram_mem[vram_ix(cpu_addr_in)];
        else if (cpu_oam_ok)
            cpu_rd = oam_mem[oam_ix(cpu_addr_in)];
    end

    always_comb begin
        ppu_valid_d = ppu_addr_valid_in;
        ppu_data_d  = ppu_addr_valid_in ? ppu_rd : ppu_data_q;
        spr_valid_d = ppu_oam_addr_valid_in;
        spr_data_d  = ppu_oam_addr_valid_in ? spr_rd : spr_data_q;
        cpu_valid_d = cpu_req_in && !cpu_we_in;
        cpu_data_d  = cpu_valid_d ? cpu_rd : cpu_data_q;
    end

    // DMA next state; a start pulse restarts from any state.
    always_comb begin
        dma_state_d = dma_state_q;
        dma_idx_d   = dma_idx_q;
        dma_src_d   = dma_src_q;
        if (dma_start_in) begin
            // Sources at $E000 and above mirror the work RAM at $C000.
            dma_src_d   = (dma_src_hi_in >= 8'hE0) ? (dma_src_hi_in - 8'h20) : dma_src_hi_in;
            dma_idx_d   = 8'd0;
            dma_state_d = DMA_REQ;
        end else begin
            case (dma_state_q)
                DMA_REQ:  dma_state_d = DMA_WAIT;
                DMA_WAIT: begin
                    if (dma_data_valid_in) begin
                        if (dma_idx_q == IDX_LAST) begin
                            dma_state_d = DMA_IDLE;
                        end else begin
                            dma_idx_d   = dma_idx_q + 8'd1;
                            dma_state_d = DMA_REQ;
                        end
                    end
                end
                DMA_IDLE: dma_state_d = DMA_IDLE;
                default:  dma_state_d = DMA_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            dma_state_q <= DMA_IDLE;
            dma_idx_q   <= 8'd0;
            dma_src_q   <= 8'd0;
            ppu_data_q  <= 8'd0;
            ppu_valid_q <= 1'b0;
            spr_data_q  <= 8'd0;
            spr_valid_q <= 1'b0;
            cpu_data_q  <= 8'd0;
            cpu_valid_q <= 1'b0;
        end else begin
            dma_state_q <= dma_state_d;
            dma_idx_q   <= dma_idx_d;
            dma_src_q   <= dma_src_d;
            ppu_data_q  <= ppu_data_d;
            ppu_valid_q <= ppu_valid_d;
            spr_data_q  <= spr_data_d;
            spr_valid_q <= spr_valid_d;
            cpu_data_q  <= cpu_data_d;
            cpu_valid_q <= cpu_valid_d;
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk_in) begin
        if (vram_we)
            vram_mem[vram_ix(cpu_addr_in)] <= cpu_wdata_in;
        if (oam_we)
            oam_mem[oam_wa] <= oam_wd;
    end

    assign ppu_data_out           = ppu_data_q;
    assign ppu_data_valid_out     = ppu_valid_q;
    assign ppu_oam_data_out       = spr_data_q;
    assign ppu_oam_data_valid_out = spr_valid_q;
    assign cpu_rdata_out          = cpu_data_q;
    assign cpu_rdata_valid_out    = cpu_valid_q;
    assign dma_addr_out           = {dma_src_q, dma_idx_q};
    assign dma_req_out            = (dma_state_q == DMA_REQ);
    assign dma_busy_out           = dma_busy;

endmodule

// File: tb/tb_video_mem_responder.sv
module tb_video_mem_responder;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [1:0]  mode_in;
    logic [15:0] ppu_addr_in;
    logic        ppu_addr_valid_in;
    logic [7:0]  ppu_data_out;
    logic        ppu_data_valid_out;
    logic [15:0] ppu_oam_addr_in;
    logic        ppu_oam_addr_valid_in;
    logic [7:0]  ppu_oam_data_out;
    logic        ppu_oam_data_valid_out;
    logic [15:0] cpu_addr_in;
    logic        cpu_req_in;
    logic        cpu_we_in;
    logic [7:0]  cpu_wdata_in;
    logic [7:0]  cpu_rdata_out;
    logic        cpu_rdata_valid_out;
    logic        dma_start_in;
    logic [7:0]  dma_src_hi_in;
    logic [15:0] dma_addr_out;
    logic        dma_req_out;
    logic [7:0]  dma_data_in;
    logic        dma_data_valid_in;
    logic        dma_busy_out;

    int checks = 0;
    int errors = 0;

    // Reference memories, indexed by byte offset from each region's base.
    logic [7:0]  vram_m [8192];
    logic [7:0]  oam_m  [160];
    logic [15:0] pool   [16];

    video_mem_responder dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .mode_in(mode_in),
        .ppu_addr_in(ppu_addr_in), .ppu_addr_valid_in(ppu_addr_valid_in),
        .ppu_data_out(ppu_data_out), .ppu_data_valid_out(ppu_data_valid_out),
        .ppu_oam_addr_in(ppu_oam_addr_in), .ppu_oam_addr_valid_in(ppu_oam_addr_valid_in),
        .ppu_oam_data_out(ppu_oam_data_out), .ppu_oam_data_valid_out(ppu_oam_data_valid_out),
        .cpu_addr_in(cpu_addr_in), .cpu_req_in(cpu_req_in), .cpu_we_in(cpu_we_in),
        .cpu_wdata_in(cpu_wdata_in), .cpu_rdata_out(cpu_rdata_out),
        .cpu_rdata_valid_out(cpu_rdata_valid_out),
        .dma_start_in(dma_start_in), .dma_src_hi_in(dma_src_hi_in),
        .dma_addr_out(dma_addr_out), .dma_req_out(dma_req_out),
        .dma_data_in(dma_data_in), .dma_data_valid_in(dma_data_valid_in),
        .dma_busy_out(dma_busy_out)
    );

    always #5 clk_in = ~clk_in;

    // Expected idle-bus read of a CPU-visible address given region rules.
    function automatic logic [7:0] model_rd(input logic [15:0] a);
        logic [12:0] vi;
        logic [7:0]  oi;
        vi = 13'(a - 16'h8000);
        oi = 8'(a - 16'hFE00);
        if (a >= 16'h8000 && a <= 16'h9FFF) return vram_m[vi];
        if (a >= 16'hFE00 && a <= 16'hFE9F) return oam_m[oi];
        return 8'hFF;
    endfunction

    // Drivers: called at a negedge, return at the next negedge with the
    // response of that access visible on the outputs.
    task automatic cpu_access(input logic [15:0] a, input logic we, input logic [7:0] d,
                              input logic [1:0] m);
        cpu_addr_in = a; cpu_we_in = we; cpu_wdata_in = d; mode_in = m; cpu_req_in = 1'b1;
        @(negedge clk_in);
        cpu_req_in = 1'b0; cpu_we_in = 1'b0;
    endtask

    task automatic ppu_read(input logic [15:0] a);
        ppu_addr_in = a; ppu_addr_valid_in = 1'b1;
        @(negedge clk_in);
        ppu_addr_valid_in = 1'b0;
    endtask

    task automatic sprite_read(input logic [15:0] a);
        ppu_oam_addr_in = a; ppu_oam_addr_valid_in = 1'b1;
        @(negedge clk_in);
        ppu_oam_addr_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        logic [59:0] outs;
        rst_n_in = 1'b1;
        #2 rst_n_in = 1'b0;
        repeat (2) @(negedge clk_in);
        outs = {ppu_data_out, ppu_data_valid_out, ppu_oam_data_out, ppu_oam_data_valid_out,
                cpu_rdata_out, cpu_rdata_valid_out, dma_addr_out, dma_req_out, dma_busy_out};
        checks++;
        if (outs !== 60'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        rst_n_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if (dma_busy_out !== 1'b0 || dma_req_out !== 1'b0) begin
            errors++; $display("FAIL reset_release_idle: busy %b req %b expected 0 0", dma_busy_out, dma_req_out);
        end
    endtask

    task automatic test_vram_rw();
        logic [15:0] a;
        logic [7:0]  d;
        cpu_access(16'h8010, 1'b1, 8'hA5, 2'd0);
        vram_m[13'h0010] = 8'hA5;
        ppu_read(16'h8010);
        checks++;
        if (ppu_data_valid_out !== 1'b1 || ppu_data_out !== 8'hA5) begin
            errors++; $display("FAIL ppu_read_8010: got v%b %h expected v1 a5", ppu_data_valid_out, ppu_data_out);
        end
        @(negedge clk_in);
        checks++;
        if (ppu_data_valid_out !== 1'b0) begin
            errors++; $display("FAIL ppu_strobe_width: got %b expected 0", ppu_data_valid_out);
        end
        for (int i = 0; i < 16; i++) begin
            a = (i == 0) ? 16'h9FFF : (i == 1) ? 16'h8000 : 16'(16'h8000 + $urandom_range(0, 8191));
            d = 8'($urandom);
            cpu_access(a, 1'b1, d, 2'($urandom_range(0, 2)));
            vram_m[13'(a - 16'h8000)] = d;
            pool[i] = a;
        end
        for (int i = 0; i < 16; i++) begin
            ppu_read(pool[i]);
            checks++;
            if (ppu_data_valid_out !== 1'b1 || ppu_data_out !== model_rd(pool[i])) begin
                errors++; $display("FAIL ppu_vram_rand @%h: got v%b %h expected v1 %h",
                                   pool[i], ppu_data_valid_out, ppu_data_out, model_rd(pool[i]));
            end
            cpu_access(pool[i], 1'b0, 8'h00, 2'($urandom_range(0, 2)));
            checks++;
            if (cpu_rdata_valid_out !== 1'b1 || cpu_rdata_out !== model_rd(pool[i])) begin
                errors++; $display("FAIL cpu_vram_rand @%h: got v%b %h expected v1 %h",
                                   pool[i], cpu_rdata_valid_out, cpu_rdata_out, model_rd(pool[i]));
            end
        end
    endtask

    task automatic test_mode_gating();
        logic [15:0] a;
        logic [7:0]  d, exp;
        int          r;
        logic [1:0]  m;
        logic        we, blocked;
        for (int i = 0; i < 160; i++) begin
            d = 8'($urandom);
            cpu_access(16'(16'hFE00 + i), 1'b1, d, 2'($urandom_range(0, 1)));
            oam_m[i] = d;
        end
        cpu_access(16'h8010, 1'b0, 8'h00, 2'd3);
        checks++;
        if (cpu_rdata_valid_out !== 1'b1 || cpu_rdata_out !== 8'hFF) begin
            errors++; $display("FAIL cpu_vram_mode3_read: got v%b %h expected v1 ff", cpu_rdata_valid_out, cpu_rdata_out);
        end
        cpu_access(16'h8010, 1'b1, 8'h3C, 2'd3);
        cpu_access(16'h8010, 1'b0, 8'h00, 2'd0);
        checks++;
        if (cpu_rdata_out !== 8'hA5) begin
            errors++; $display("FAIL cpu_vram_mode3_write_dropped: got %h expected a5", cpu_rdata_out);
        end
        cpu_access(16'hFE05, 1'b1, 8'h77, 2'd2);
        cpu_access(16'hFE05, 1'b0, 8'h00, 2'd2);
        checks++;
        if (cpu_rdata_valid_out !== 1'b1 || cpu_rdata_out !== 8'hFF) begin
            errors++; $display("FAIL cpu_oam_mode2_read: got v%b %h expected v1 ff", cpu_rdata_valid_out, cpu_rdata_out);
        end
        sprite_read(16'hFE05);
        checks++;
        if (ppu_oam_data_valid_out !== 1'b1 || ppu_oam_data_out !== oam_m[5]) begin
            errors++; $display("FAIL sprite_read_fe05: got v%b %h expected v1 %h", ppu_oam_data_valid_out, ppu_oam_data_out, oam_m[5]);
        end
        sprite_read(16'hFE9F);
        checks++;
        if (ppu_oam_data_out !== oam_m[159]) begin
            errors++; $display("FAIL sprite_read_fe9f: got %h expected %h", ppu_oam_data_out, oam_m[159]);
        end
        ppu_read(16'h7FFF);
        checks++;
        if (ppu_data_out !== 8'hFF) begin
            errors++; $display("FAIL ppu_unmapped_7fff: got %h expected ff", ppu_data_out);
        end
        ppu_read(16'hFEA0);
        checks++;
        if (ppu_data_out !== 8'hFF) begin
            errors++; $display("FAIL ppu_unmapped_fea0: got %h expected ff", ppu_data_out);
        end
        // Random accesses across regions and modes.
        for (int i = 0; i < 48; i++) begin
            r  = int'($urandom_range(0, 2));
            m  = 2'($urandom_range(0, 3));
            we = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            if (r == 0)      a = pool[$urandom_range(0, 15)];
            else if (r == 1) a = 16'(16'hFE00 + $urandom_range(0, 159));
            else if ($urandom_range(0, 1) == 1) a = 16'($urandom_range(16'hA000, 16'hFDFF));
            else             a = 16'($urandom_range(16'hFEA0, 16'hFFFF));
            blocked = (r == 0 && m == 2'd3) || (r == 1 && m >= 2'd2);
            if (we) begin
                cpu_access(a, 1'b1, d, m);
                if (r == 0 && !blocked) vram_m[13'(a - 16'h8000)] = d;
                if (r == 1 && !blocked) oam_m[8'(a - 16'hFE00)] = d;
                ppu_read(a);
                exp = model_rd(a);
                checks++;
                if (ppu_data_out !== exp) begin
                    errors++; $display("FAIL gating_write_rand @%h mode %0d: got %h expected %h", a, m, ppu_data_out, exp);
                end
            end else begin
                cpu_access(a, 1'b0, 8'h00, m);
                exp = blocked ? 8'hFF : model_rd(a);
                checks++;
                if (cpu_rdata_valid_out !== 1'b1 || cpu_rdata_out !== exp) begin
                    errors++; $display("FAIL gating_read_rand @%h mode %0d: got v%b %h expected v1 %h",
                                       a, m, cpu_rdata_valid_out, cpu_rdata_out, exp);
                end
            end
        end
    endtask

    task automatic test_dma();
        int          count, cyc, delay;
        bit          pending;
        logic [7:0]  pdata;
        logic [15:0] exp_addr;
        count = 0; cyc = 0; delay = 0; pending = 1'b0; pdata = 8'h00;
        mode_in = 2'd0;
        dma_src_hi_in = 8'hC1; dma_start_in = 1'b1;
        @(negedge clk_in);
        dma_start_in = 1'b0;
        checks++;
        if (dma_busy_out !== 1'b1) begin
            errors++; $display("FAIL dma_busy_rise: got %b expected 1", dma_busy_out);
        end
        while (dma_busy_out === 1'b1 && cyc < 3000) begin
            dma_data_valid_in = 1'b0;
            // Every OAM read sampled while busy must come back as FF.
            if (ppu_oam_data_valid_out === 1'b1) begin
                checks++;
                if (ppu_oam_data_out !== 8'hFF) begin
                    errors++; $display("FAIL dma_sprite_blocked: got %h expected ff", ppu_oam_data_out);
                end
            end
            if (cpu_rdata_valid_out === 1'b1) begin
                checks++;
                if (cpu_rdata_out !== 8'hFF) begin
                    errors++; $display("FAIL dma_cpu_oam_blocked: got %h expected ff", cpu_rdata_out);
                end
            end
            ppu_oam_addr_in = 16'(16'hFE00 + $urandom_range(0, 159)); ppu_oam_addr_valid_in = 1'b1;
            cpu_addr_in = 16'(16'hFE00 + $urandom_range(0, 159)); cpu_we_in = 1'b0; cpu_req_in = 1'b1;
            if (pending) begin
                if (delay == 0) begin
                    dma_data_valid_in = 1'b1; dma_data_in = pdata; pending = 1'b0;
                end else delay--;
            end
            if (dma_req_out === 1'b1) begin
                exp_addr = {8'hC1, 8'(count)};
                checks++;
                if (dma_addr_out !== exp_addr) begin
                    errors++; $display("FAIL dma_req_addr #%0d: got %h expected %h", count, dma_addr_out, exp_addr);
                end
                pdata = dma_addr_out[7:0] + 8'd1; pending = 1'b1; delay = 1; count++;
            end
            @(negedge clk_in);
            cyc++;
        end
        dma_data_valid_in = 1'b0; ppu_oam_addr_valid_in = 1'b0; cpu_req_in = 1'b0;
        checks++;
        if (count != 160 || dma_busy_out !== 1'b0) begin
            errors++; $display("FAIL dma_req_count: got %0d busy %b expected 160 busy 0", count, dma_busy_out);
        end
        for (int i = 0; i < 160; i++) oam_m[i] = 8'(i + 1);
        for (int i = 0; i < 160; i++) begin
            sprite_read(16'(16'hFE00 + i));
            checks++;
            if (ppu_oam_data_out !== oam_m[i]) begin
                errors++; $display("FAIL dma_oam_content[%0d]: got %h expected %h", i, ppu_oam_data_out, oam_m[i]);
            end
        end
    endtask

    task automatic test_dma_restart();
        int          count, cyc, delay;
        bit          pending, restarted;
        logic [7:0]  pdata, exp_src, exp_idx;
        logic [15:0] exp_addr;
        count = 0; cyc = 0; delay = 0; pending = 1'b0; restarted = 1'b0; pdata = 8'h00;
        exp_src = 8'hC3; exp_idx = 8'h00;
        dma_src_hi_in = 8'hE3; dma_start_in = 1'b1;
        @(negedge clk_in);
        dma_start_in = 1'b0;
        while (dma_busy_out === 1'b1 && cyc < 4000) begin
            dma_data_valid_in = 1'b0;
            dma_start_in = 1'b0;
            if (pending) begin
                if (delay == 0) begin
                    dma_data_valid_in = 1'b1; dma_data_in = pdata; pending = 1'b0;
                end else delay--;
            end
            if (dma_req_out === 1'b1) begin
                exp_addr = {exp_src, exp_idx};
                checks++;
                if (dma_addr_out !== exp_addr) begin
                    errors++; $display("FAIL restart_req_addr #%0d: got %h expected %h", count, dma_addr_out, exp_addr);
                end
                pdata = dma_addr_out[7:0] + dma_addr_out[15:8]; pending = 1'b1; delay = 1;
                count++; exp_idx++;
                if (count == 51 && !restarted) begin
                    // Restart while idx 50 is being requested; its data never arrives.
                    restarted = 1'b1; pending = 1'b0;
                    dma_src_hi_in = 8'h12; dma_start_in = 1'b1;
                    exp_src = 8'h12; exp_idx = 8'h00;
                end
            end
            @(negedge clk_in);
            cyc++;
        end
        dma_data_valid_in = 1'b0; dma_start_in = 1'b0;
        checks++;
        if (count != 211 || dma_busy_out !== 1'b0) begin
            errors++; $display("FAIL restart_req_count: got %0d busy %b expected 211 busy 0", count, dma_busy_out);
        end
        for (int i = 0; i < 160; i++) oam_m[i] = 8'(i + 8'h12);
        for (int i = 0; i < 160; i += 7) begin
            sprite_read(16'(16'hFE00 + i));
            checks++;
            if (ppu_oam_data_out !== oam_m[i]) begin
                errors++; $display("FAIL restart_oam_content[%0d]: got %h expected %h", i, ppu_oam_data_out, oam_m[i]);
            end
        end
    endtask

    task automatic test_reset_mid_dma();
        int cyc;
        cyc = 0;
        dma_src_hi_in = 8'hC1; dma_start_in = 1'b1;
        @(negedge clk_in);
        dma_start_in = 1'b0;
        while (dma_req_out !== 1'b1 && cyc < 10) begin
            @(negedge clk_in); cyc++;
        end
        checks++;
        if (dma_req_out !== 1'b1) begin
            errors++; $display("FAIL midreset_setup_req: got %b expected 1", dma_req_out);
        end
        rst_n_in = 1'b0;
        #1;
        checks++;
        if (dma_busy_out !== 1'b0 || dma_req_out !== 1'b0 || dma_addr_out !== 16'h0000) begin
            errors++; $display("FAIL midreset_async: got busy %b req %b addr %h expected 0 0 0000",
                               dma_busy_out, dma_req_out, dma_addr_out);
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (3) @(negedge clk_in);
        checks++;
        if (dma_busy_out !== 1'b0) begin
            errors++; $display("FAIL midreset_stays_idle: got %b expected 0", dma_busy_out);
        end
        ppu_read(16'h8010);
        checks++;
        if (ppu_data_out !== 8'hA5) begin
            errors++; $display("FAIL vram_kept_over_reset: got %h expected a5", ppu_data_out);
        end
    endtask

    task automatic test_collision();
        logic [7:0] old_v, new_v;
        old_v = 8'($urandom);
        new_v = ~old_v;
        cpu_access(16'h9000, 1'b1, old_v, 2'd0);
        vram_m[13'h1000] = old_v;
        cpu_addr_in = 16'h9000; cpu_we_in = 1'b1; cpu_wdata_in = new_v; mode_in = 2'd0; cpu_req_in = 1'b1;
        ppu_addr_in = 16'h9000; ppu_addr_valid_in = 1'b1;
        @(negedge clk_in);
        cpu_req_in = 1'b0; cpu_we_in = 1'b0; ppu_addr_valid_in = 1'b0;
        checks++;
        if (ppu_data_valid_out !== 1'b1 || ppu_data_out !== old_v) begin
            errors++; $display("FAIL collision_read_first: got v%b %h expected v1 %h", ppu_data_valid_out, ppu_data_out, old_v);
        end
        vram_m[13'h1000] = new_v;
        ppu_read(16'h9000);
        checks++;
        if (ppu_data_out !== new_v) begin
            errors++; $display("FAIL collision_new_visible: got %h expected %h", ppu_data_out, new_v);
        end
    endtask

    initial begin
        rst_n_in = 1'b1; mode_in = 2'd0;
        ppu_addr_in = 16'h0; ppu_addr_valid_in = 1'b0;
        ppu_oam_addr_in = 16'h0; ppu_oam_addr_valid_in = 1'b0;
        cpu_addr_in = 16'h0; cpu_req_in = 1'b0; cpu_we_in = 1'b0; cpu_wdata_in = 8'h0;
        dma_start_in = 1'b0; dma_src_hi_in = 8'h0; dma_data_in = 8'h0; dma_data_valid_in = 1'b0;
        test_reset();
        test_vram_rw();
        test_mode_gating();
        test_dma();
        test_dma_restart();
        test_reset_mid_dma();
        test_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_mem_responder.md
Name: video_mem_responder

Overview:
Memory-side responder for the pixel processing unit's VRAM and OAM request ports. It owns the 8 KiB VRAM and the 160-byte OAM, and answers PPU reads with fixed one-cycle latency. It also serves CPU reads and writes, gated by the current PPU mode, and runs the OAM DMA engine, which copies 160 bytes from the external bus into OAM.

Parameters:
VRAM_BASE, 16'h8000, first VRAM address (VRAM spans 8 KiB)
OAM_BASE, 16'hFE00, first OAM address
OAM_BYTES, 160, OAM size and DMA transfer length

Ports:
clk_in  input  1  system clock; the only clock
rst_n_in  input  1  asynchronous, active-low reset
mode_in  input  2  PPU mode (0 HBlank, 1 VBlank, 2 OAMScan, 3 Draw)
ppu_addr_in  input  16  PPU general read address (VRAM or OAM)
ppu_addr_valid_in  input  1  PPU general read request
ppu_data_out  output  8  read data for the general port
ppu_data_valid_out  output  1  general-port response strobe
ppu_oam_addr_in  input  16  PPU sprite-flag read address
ppu_oam_addr_valid_in  input  1  sprite-flag read request
ppu_oam_data_out  output  8  sprite-flag read data
ppu_oam_data_valid_out  output  1  sprite-flag response strobe
cpu_addr_in  input  16  CPU address
cpu_req_in  input  1  CPU access request
cpu_we_in  input  1  1 = write, 0 = read
cpu_wdata_in  input  8  CPU write data
cpu_rdata_out  output  8  CPU read data
cpu_rdata_valid_out  output  1  CPU read response strobe
dma_start_in  input  1  one-cycle pulse from the $FF46 write
dma_src_hi_in  input  8  DMA source high byte
dma_addr_out  output  16  DMA bus read address
dma_req_out  output  1  DMA bus read request (one-cycle pulse)
dma_data_in  input  8  DMA bus read data
dma_data_valid_in  input  1  DMA bus data strobe
dma_busy_out  output  1  DMA in progress

Behaviour:
- Reset (asynchronous, rst_n_in=0):
  - all outputs go to 0; the DMA FSM goes to IDLE and the DMA index to 0.
  - VRAM and OAM contents are not reset.
  - Reset during a DMA aborts it immediately.
- Decode:
  - VRAM hit: addr in [VRAM_BASE, VRAM_BASE+8191].
  - OAM hit: addr in [OAM_BASE, OAM_BASE+159].
  - Any other address is unmapped; reads return 8'hFF, writes are ignored.
- PPU ports:
  - A request at edge N gives valid_out=1 with data at edge N+1; the strobe lasts one cycle.
  - Both PPU ports respond every cycle. No back-pressure, no mode gating.
  - During dma_busy_out, PPU OAM reads return 8'hFF.
- CPU port:
  - Reads follow the same one-cycle latency as the PPU ports. Writes produce no response.
  - Blocked accesses: VRAM when mode_in==3; OAM when mode_in is 2 or 3, or when dma_busy_out=1.
  - A blocked read returns 8'hFF with the valid strobe. A blocked write is dropped.
  - Mode is sampled at the request edge.
- Same-cycle collisions:
  - Memories are read-first. A PPU read and a CPU write to the same byte in the same cycle return the old value; the new value is visible from the next request.
  - A DMA OAM write wins over a CPU OAM write (the CPU write is blocked anyway).
- DMA FSM (IDLE, REQ, WAIT):
  - IDLE: on dma_start_in, latch src_hi, set idx=0, go to REQ; dma_busy_out=1 from the next edge.
  - Source mapping: if src_hi >= 8'hE0, use src_hi - 8'h20 (echo mapping).
  - REQ: dma_addr_out = {src, idx[7:0]}, dma_req_out=1 for exactly one cycle, then go to WAIT.
  - WAIT: on dma_data_valid_in, write OAM[idx] = dma_data_in.
    - If idx == OAM_BYTES-1: go to IDLE and clear busy.
    - Otherwise: idx++ and go to REQ.
  - dma_start_in in REQ or WAIT restarts the transfer: new src latched, idx=0, go to REQ. A pending bus response is discarded.
  - dma_data_valid_in outside WAIT is ignored.
  - Minimum transfer time: 160 × (2 + bus latency) cycles.
- Widths:
  - idx is 8 bits.
  - VRAM index = addr - VRAM_BASE, 13 bits.
  - OAM index = addr - OAM_BASE, 8 bits.

Test Plan:
- Reset, then CPU writes 8'hA5 to 16'h8010 in mode 0; PPU reads 16'h8010 -> ppu_data_out=8'hA5 and ppu_data_valid_out=1 exactly one cycle after the request.
- Mode 3: CPU reads 16'h8010 -> cpu_rdata_out=8'hFF. CPU writes 8'h3C to 16'h8010, then reads it in mode 0 -> 8'hA5 (write dropped).
- Mode 2: CPU write to 16'hFE05 is dropped and a CPU read returns 8'hFF. The PPU sprite port reading 16'hFE05 still returns the stored byte.
- DMA with dma_src_hi_in=8'hC1, bus responding with data = low address byte plus 1 after 2 cycles:
  - 160 dma_req_out pulses at addresses 16'hC100..16'hC19F.
  - OAM[i] = i+1 afterwards.
  - dma_busy_out falls after the last write.
- DMA with src 8'hE3 -> first dma_addr_out=16'hC300. dma_start_in pulsed mid-transfer (idx=50) -> idx restarts at 0 and a full 160 requests follow.
- rst_n_in asserted mid-DMA -> dma_busy_out=0 and dma_req_out=0 immediately (asynchronously). Same-cycle CPU write/PPU read of 16'h9000 -> PPU sees the old value.
